// File: rtl/reg_debug_master.sv
// Debug master that runs READ/WRITE/DUMP/CLEAR commands against an external register file
// and streams register contents back as responses. Define RDM_CLEAR_EN to enable CLEAR.
module reg_debug_master #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [1:0]                cmd_op,
  input  logic [REG_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0]     cmd_data,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [REG_ADDR_WIDTH-1:0] rsp_addr,
  output logic [DATA_WIDTH-1:0]     rsp_data,
  output logic                      rsp_last,
  output logic                      rsp_err,
  output logic [REG_ADDR_WIDTH-1:0] rf_read_addr,
  input  logic [DATA_WIDTH-1:0]     rf_read_data,
  output logic                      rf_write_en,
  output logic [REG_ADDR_WIDTH-1:0] rf_write_addr,
  output logic [DATA_WIDTH-1:0]     rf_write_data,
  output logic                      busy
);

  localparam logic [REG_ADDR_WIDTH-1:0] LastIdx = '1;
  localparam logic [REG_ADDR_WIDTH-1:0] OneIdx  = REG_ADDR_WIDTH'(1);

  typedef enum logic [2:0] {StIdle, StRead, StWrite, StDump, StClear, StResp} state_e;

  state_e                    state_q, state_d;
  logic [REG_ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                      cmd_ready_q, cmd_ready_d;
  logic                      rsp_valid_q, rsp_valid_d;
  logic [REG_ADDR_WIDTH-1:0] rsp_addr_q, rsp_addr_d;
  logic [DATA_WIDTH-1:0]     rsp_data_q, rsp_data_d;
  logic                      rsp_last_q, rsp_last_d;
  logic                      rsp_err_q, rsp_err_d;
  logic [REG_ADDR_WIDTH-1:0] rf_read_addr_q, rf_read_addr_d;
  logic                      rf_write_en_q, rf_write_en_d;
  logic [REG_ADDR_WIDTH-1:0] rf_write_addr_q, rf_write_addr_d;
  logic [DATA_WIDTH-1:0]     rf_write_data_q, rf_write_data_d;
  logic                      busy_q, busy_d;

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    cmd_ready_d     = cmd_ready_q;
    rsp_valid_d     = rsp_valid_q;
    rsp_addr_d      = rsp_addr_q;
    rsp_data_d      = rsp_data_q;
    rsp_last_d      = rsp_last_q;
    rsp_err_d       = rsp_err_q;
    rf_read_addr_d  = rf_read_addr_q;
    rf_write_en_d   = rf_write_en_q;
    rf_write_addr_d = rf_write_addr_q;
    rf_write_data_d = rf_write_data_q;

    unique case (state_q)
      StIdle: begin
        // cmd_ready is registered, so it first rises one edge after reset release
        cmd_ready_d = 1'b1;
        if (cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          unique case (cmd_op)
            2'b00: begin
              state_d        = StRead;
              rf_read_addr_d = cmd_addr;
            end
            2'b01: begin
              state_d         = StWrite;
              rf_write_en_d   = 1'b1;
              rf_write_addr_d = cmd_addr;
              rf_write_data_d = cmd_data;
            end
            2'b10: begin
              state_d        = StDump;
              cnt_d          = '0;
              rf_read_addr_d = '0;
            end
            default: begin
              state_d = StClear;
`ifdef RDM_CLEAR_EN
              rf_write_en_d   = 1'b1;
              rf_write_addr_d = OneIdx;
              rf_write_data_d = '0;
`endif
            end
          endcase
        end
      end

      StRead: begin
        rsp_valid_d = 1'b1;
        rsp_addr_d  = rf_read_addr_q;
        rsp_data_d  = rf_read_data;
        rsp_last_d  = 1'b1;
        rsp_err_d   = 1'b0;
        state_d     = StResp;
      end

      StWrite: begin
        rf_write_en_d = 1'b0;
        cmd_ready_d   = 1'b1;
        state_d       = StIdle;
      end

      StDump: begin
        rsp_valid_d = 1'b1;
        rsp_addr_d  = cnt_q;
        rsp_data_d  = rf_read_data;
        rsp_last_d  = (cnt_q == LastIdx);
        rsp_err_d   = 1'b0;
        state_d     = StResp;
      end

      StClear: begin
`ifdef RDM_CLEAR_EN
        // Walk indices 1..NREG-1; index 0 is hardwired and never written
        if (rf_write_addr_q == LastIdx) begin
          rf_write_en_d = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_addr_d    = '0;
          rsp_data_d    = '0;
          rsp_last_d    = 1'b1;
          rsp_err_d     = 1'b0;
          state_d       = StResp;
        end else begin
          rf_write_addr_d = rf_write_addr_q + OneIdx;
        end
`else
        rsp_valid_d = 1'b1;
        rsp_addr_d  = '0;
        rsp_data_d  = '0;
        rsp_last_d  = 1'b1;
        rsp_err_d   = 1'b1;
        state_d     = StResp;
`endif
      end

      StResp: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          if (rsp_last_q) begin
            cnt_d       = '0;
            cmd_ready_d = 1'b1;
            state_d     = StIdle;
          end else begin
            // Only DUMP produces non-last responses: advance to the next index
            cnt_d          = cnt_q + OneIdx;
            rf_read_addr_d = cnt_q + OneIdx;
            state_d        = StDump;
          end
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= StIdle;
      cnt_q           <= '0;
      cmd_ready_q     <= 1'b0;
      rsp_valid_q     <= 1'b0;
      rsp_addr_q      <= '0;
      rsp_data_q      <= '0;
      rsp_last_q      <= 1'b0;
      rsp_err_q       <= 1'b0;
      rf_read_addr_q  <= '0;
      rf_write_en_q   <= 1'b0;
      rf_write_addr_q <= '0;
      rf_write_data_q <= '0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      cmd_ready_q     <= cmd_ready_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_addr_q      <= rsp_addr_d;
      rsp_data_q      <= rsp_data_d;
      rsp_last_q      <= rsp_last_d;
      rsp_err_q       <= rsp_err_d;
      rf_read_addr_q  <= rf_read_addr_d;
      rf_write_en_q   <= rf_write_en_d;
      rf_write_addr_q <= rf_write_addr_d;
      rf_write_data_q <= rf_write_data_d;
      busy_q          <= busy_d;
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_addr      = rsp_addr_q;
  assign rsp_data      = rsp_data_q;
  assign rsp_last      = rsp_last_q;
  assign rsp_err       = rsp_err_q;
  assign rf_read_addr  = rf_read_addr_q;
  assign rf_write_en   = rf_write_en_q;
  assign rf_write_addr = rf_write_addr_q;
  assign rf_write_data = rf_write_data_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_reg_debug_master.sv
// Scoreboard bench for reg_debug_master with a behavioural register file (index 0 reads 0).
module tb_reg_debug_master;

  localparam logic [1:0] OpRead = 2'b00, OpWrite = 2'b01, OpDump = 2'b10, OpClear = 2'b11;
`ifdef RDM_CLEAR_EN
  localparam logic [31:0] ClrVal = 32'h0;
  localparam int unsigned ClrWrites = 31;
  localparam logic ClrErr = 1'b0;
`else
  localparam logic [31:0] ClrVal = 32'hA5A5A5A5;
  localparam int unsigned ClrWrites = 0;
  localparam logic ClrErr = 1'b1;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_op;
  logic [4:0]  cmd_addr;
  logic [31:0] cmd_data;
  logic        rsp_valid, rsp_ready;
  logic [4:0]  rsp_addr;
  logic [31:0] rsp_data;
  logic        rsp_last, rsp_err;
  logic [4:0]  rf_read_addr, rf_write_addr;
  logic [31:0] rf_read_data, rf_write_data;
  logic        rf_write_en, busy;

  reg_debug_master dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_addr     (cmd_addr),
    .cmd_data     (cmd_data),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_addr     (rsp_addr),
    .rsp_data     (rsp_data),
    .rsp_last     (rsp_last),
    .rsp_err      (rsp_err),
    .rf_read_addr (rf_read_addr),
    .rf_read_data (rf_read_data),
    .rf_write_en  (rf_write_en),
    .rf_write_addr(rf_write_addr),
    .rf_write_data(rf_write_data),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Register file model
  logic [31:0] rf [32];
  int wr_count = 0;
  int wr0_count = 0;
  assign rf_read_data = (rf_read_addr == 5'd0) ? 32'h0 : rf[rf_read_addr];
  always @(posedge clk) begin
    if (rf_write_en) begin
      wr_count <= wr_count + 1;
      if (rf_write_addr == 5'd0) wr0_count <= wr0_count + 1;
      else rf[rf_write_addr] <= rf_write_data;
    end
  end

  // 0: hold low, 1: hold high, 2: toggle every cycle
  int rdy_mode = 1;
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       rsp_ready = 1'b0;
      1:       rsp_ready = 1'b1;
      default: rsp_ready = ~rsp_ready;
    endcase
  end

  int n_tests = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
    logic        last;
    logic        err;
  } exp_t;
  exp_t sb[$];
  logic mon_en = 1'b1;
  int   rsp_count = 0;

  task automatic push(input logic [4:0] a, input logic [31:0] d, input logic l, input logic e);
    exp_t x;
    x.addr = a; x.data = d; x.last = l; x.err = e;
    sb.push_back(x);
  endtask

  // A response is consumed at the edge following a negedge where valid&&ready are both seen
  always @(negedge clk) begin
    if (mon_en && reset && rsp_valid && rsp_ready) begin
      rsp_count++;
      if (sb.size() == 0) begin
        check("rsp_unexpected", 64'(rsp_addr), 64'hFFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rsp_addr", 64'(rsp_addr), 64'(e.addr));
        check("rsp_data", 64'(rsp_data), 64'(e.data));
        check("rsp_last", 64'(rsp_last), 64'(e.last));
        check("rsp_err", 64'(rsp_err), 64'(e.err));
      end
    end
  end

  task automatic send_cmd(input logic [1:0] op, input logic [4:0] a, input logic [31:0] d);
    int n;
    n = 0;
    @(negedge clk);
    cmd_op = op; cmd_addr = a; cmd_data = d; cmd_valid = 1'b1;
    while (!cmd_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) check("cmd_accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (!(cmd_ready && sb.size() == 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!(cmd_ready && sb.size() == 0)) check("idle_timeout", 64'd0, 64'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, 64'({cmd_ready, rsp_valid, rsp_last, rsp_err, rf_write_en, busy}), 64'd0);
    check({tag, "_rsp"}, {27'd0, rsp_addr, rsp_data}, 64'd0);
    check({tag, "_rf"}, {22'd0, rf_read_addr, rf_write_addr, rf_write_data}, 64'd0);
  endtask

  initial begin
    int base, base0, n;
    logic hit;
    for (int i = 0; i < 32; i++) rf[i] = 32'h0;
    reset = 1'b0;
    cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr = '0; cmd_data = '0;
    #12;
    check_all_zero("reset");
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_reset", 64'(cmd_ready), 64'd1);
    check("busy_idle", 64'(busy), 64'd0);

    // Write then read back, with response latency check
    base = wr_count;
    send_cmd(OpWrite, 5'd5, 32'h12345678);
    wait_idle();
    check("write_pulses", 64'(wr_count - base), 64'd1);
    push(5'd5, 32'h12345678, 1'b1, 1'b0);
    send_cmd(OpRead, 5'd5, 32'h0);
    check("rd_lat_edge1", 64'(rsp_valid), 64'd0);
    @(posedge clk);
    #1;
    check("rd_lat_edge2", 64'(rsp_valid), 64'd1);
    wait_idle();

    // Register 0 is hardwired: write is issued but reads back 0
    base0 = wr0_count;
    send_cmd(OpWrite, 5'd0, 32'hFFFFFFFF);
    wait_idle();
    check("addr0_write_issued", 64'(wr0_count - base0), 64'd1);
    push(5'd0, 32'h0, 1'b1, 1'b0);
    send_cmd(OpRead, 5'd0, 32'h0);
    wait_idle();

    // Fill, clear, then dump under toggling backpressure
    for (int i = 1; i < 32; i++) send_cmd(OpWrite, 5'(i), 32'hA5A5A5A5);
    wait_idle();
    base = wr_count;
    base0 = wr0_count;
    push(5'd0, 32'h0, 1'b1, ClrErr);
    send_cmd(OpClear, 5'd0, 32'h0);
    wait_idle();
    check("clear_writes", 64'(wr_count - base), 64'(ClrWrites));
    check("clear_addr0", 64'(wr0_count - base0), 64'd0);

    rdy_mode = 2;
    base = rsp_count;
    for (int i = 0; i < 32; i++) push(5'(i), (i == 0) ? 32'h0 : ClrVal, i == 31, 1'b0);
    send_cmd(OpDump, 5'd0, 32'h0);
    wait_idle();
    check("dump_count", 64'(rsp_count - base), 64'd32);

    // Held cmd_valid while a response is back-pressured
    rdy_mode = 0;
    @(posedge clk);
    #2;
    push(5'd5, ClrVal, 1'b1, 1'b0);
    send_cmd(OpRead, 5'd5, 32'h0);
    cmd_valid = 1'b1; cmd_op = OpRead; cmd_addr = 5'd1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("ready_low_while_busy", 64'(cmd_ready), 64'd0);
    end
    check("rsp_pending", 64'(rsp_valid), 64'd1);
    push(5'd1, ClrVal, 1'b1, 1'b0);
    rdy_mode = 1;
    send_cmd(OpRead, 5'd1, 32'h0);
    check("first_rsp_before_second_cmd", 64'(sb.size()), 64'd1);
    wait_idle();

    // Reset in the middle of a dump
    mon_en = 1'b0;
    send_cmd(OpDump, 5'd0, 32'h0);
    hit = 1'b0;
    n = 0;
    while (!hit && n < 500) begin
      @(negedge clk);
      n++;
      if (rsp_valid && rsp_addr == 5'd10) hit = 1'b1;
    end
    check("dump_idx10_reached", 64'(hit), 64'd1);
    #1;
    reset = 1'b0;
    #1;
    check_all_zero("mid_reset");
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_mid_reset", 64'(cmd_ready), 64'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("no_stale_rsp", 64'(rsp_valid), 64'd0);
    end
    mon_en = 1'b1;

    push(5'd5, ClrVal, 1'b1, 1'b0);
    send_cmd(OpRead, 5'd5, 32'h0);
    wait_idle();
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
